mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single 8x8 multiplier between N requesters. It accepts operand requests, grants one requester at a time, and drives the multiplier's `a`/`b`/`en` inputs. It detects the multiplier's `ack`, returns the 16-bit product to the granted requester, and recovers from a multiplier that never acknowledges. It sits between the client logic and the multiplier's RTL-side port (`a`, `b`, `en` in; `out`, `ack` out).

---
 rtl/mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_mult_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | mult_arbiter                                                             |
// | Round-robin arbiter/sequencer sharing one 8x8 multiplier among N clients |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_arbiter #(
  parameter int N         = 4,
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*8-1:0] req_a,
  input  logic [N*8-1:0] req_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [15:0]    rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [7:0]     m_a,
  output logic [7:0]     m_b,
  output logic           m_en,
  input  logic [15:0]    m_out,
  input  logic           m_ack
);

  localparam int           c_ptr_w = $clog2(N);
  localparam int           c_to_w  = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] c_one   = N'(1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_issue = 2'd1,
    st_wait  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_ptr_w-1:0]  r_ptr;
  logic [c_ptr_w-1:0]  r_id;
  logic [3:0]          r_en_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_ack_q;
  logic [c_ptr_w-1:0]  w_sel;
  logic                w_found;
  logic                w_ack_rise;

  // Only a fresh edge completes; an ack already high at grant is ignored.
  assign w_ack_rise = m_ack & ~r_ack_q;

  always_comb begin
    logic [c_ptr_w-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int i = 0; i < N; i++) begin
      v_idx = c_ptr_w'((int'(r_ptr) + i) % N);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= st_idle;
      r_ptr     <= '0;
      r_id      <= '0;
      r_en_cnt  <= '0;
      r_to_cnt  <= '0;
      r_ack_q   <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      m_a       <= '0;
      m_b       <= '0;
      m_en      <= 1'b0;
    end else begin
      r_ack_q   <= m_ack;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (r_state)
        st_idle: begin
          if (w_found) begin
            gnt      <= c_one << w_sel;
            m_a      <= req_a[{w_sel, 3'b000} +: 8];
            m_b      <= req_b[{w_sel, 3'b000} +: 8];
            m_en     <= 1'b1;
            busy     <= 1'b1;
            r_id     <= w_sel;
            r_ptr    <= c_ptr_w'((int'(w_sel) + 1) % N);
            r_en_cnt <= '0;
            r_state  <= st_issue;
          end
        end
        st_issue: begin
          if (w_ack_rise) begin
            rsp_valid <= c_one << r_id;
            rsp_data  <= m_out;
            m_en      <= 1'b0;
            busy      <= 1'b0;
            r_state   <= st_idle;
          end else if (r_en_cnt == 4'(EN_CYCLES - 1)) begin
            m_en     <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= st_wait;
          end else begin
            r_en_cnt <= r_en_cnt + 4'd1;
          end
        end
        st_wait: begin
          if (w_ack_rise) begin
            rsp_valid <= c_one << r_id;
            rsp_data  <= m_out;
            busy      <= 1'b0;
            r_state   <= st_idle;
          end else if (r_to_cnt == c_to_w'(TIMEOUT)) begin
            // Multiplier never answered: error completion with a zero product.
            rsp_valid <= c_one << r_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            busy      <= 1'b0;
            r_state   <= st_idle;
          end else begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
          end
        end
        default: r_state <= st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_mult_arbiter                                                          |
// | Self-checking bench for mult_arbiter with a cycle-level reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_arbiter;

  localparam int N     = 4;
  localparam int EN    = 2;
  localparam int TO    = 64;
  localparam int STUCK = 99;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [7:0]     m_a;
  logic [7:0]     m_b;
  logic           m_en;
  logic [15:0]    m_out = '0;
  logic           m_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_lat = 3;
  int mcnt = 0;

  mult_arbiter #(.N(N), .EN_CYCLES(EN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .m_a(m_a), .m_b(m_b), .m_en(m_en), .m_out(m_out), .m_ack(m_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  // Multiplier model: ack held from ack_lat cycles into the operation until it ends.
  always @(posedge clk) begin
    #2;
    if (busy) mcnt++; else mcnt = 0;
    if (ack_lat == STUCK) m_ack = 1'b1;
    else m_ack = (ack_lat != 0) && busy && (mcnt >= ack_lat);
    m_out = m_ack ? 16'(m_a) * 16'(m_b) : 16'hbeef;
  end

  // Reference model: derives every output of every cycle from the arbitration rules.
  bit             md_idle = 1'b1;
  int             md_ptr = 0;
  int             md_id = 0;
  int             md_age = 0;
  logic [7:0]     md_a = '0;
  logic [7:0]     md_b = '0;
  logic [15:0]    md_data = '0;
  logic [N-1:0]   p_req = '0;
  logic [N*8-1:0] p_a = '0;
  logic [N*8-1:0] p_b = '0;
  bit             p_ack = 1'b0;
  bit             p_rise = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    logic         e_err;
    logic         e_en;
    int           k;
    bit           f;
    e_gnt = '0;
    e_rv  = '0;
    e_err = 1'b0;
    if (!reset_n) begin
      md_idle = 1'b1; md_ptr = 0; md_age = 0; md_data = '0;
      p_req = '0; p_ack = 1'b0; p_rise = 1'b0;
      check("mon_reset", 64'({gnt, rsp_valid, rsp_err, m_en, busy, rsp_data, m_a, m_b}), 64'(0));
    end else begin
      if (md_idle) begin
        f = 1'b0;
        for (int i = 0; i < N; i++) begin
          k = (md_ptr + i) % N;
          if (!f && p_req[k]) begin f = 1'b1; md_id = k; end
        end
        if (f) begin
          e_gnt   = onehot(md_id);
          md_a    = p_a[md_id*8 +: 8];
          md_b    = p_b[md_id*8 +: 8];
          md_ptr  = (md_id + 1) % N;
          md_idle = 1'b0;
          md_age  = 0;
        end
      end else begin
        md_age++;
        if (p_rise) begin
          e_rv = onehot(md_id); md_data = 16'(md_a) * 16'(md_b); md_idle = 1'b1;
        end else if (md_age == EN + TO + 1) begin
          e_rv = onehot(md_id); e_err = 1'b1; md_data = '0; md_idle = 1'b1;
        end
      end
      e_en = !md_idle && (md_age < EN);
      check("mon_cycle", 64'({gnt, rsp_valid, rsp_err, m_en, busy, rsp_data}),
            64'({e_gnt, e_rv, e_err, e_en, !md_idle, md_data}));
      if (!md_idle) check("mon_operands", 64'({m_a, m_b}), 64'({md_a, md_b}));
      p_rise = m_ack && !p_ack;
      p_ack  = m_ack;
      p_req  = req;
      p_a    = req_a;
      p_b    = req_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits at negedges for a grant (want_rsp=0) or a response (want_rsp=1).
  task automatic wait_evt(input bit want_rsp, input int limit, output logic [N-1:0] v, output int c);
    bit done;
    done = 1'b0;
    v = '0;
    c = cyc;
    for (int t = 0; t < limit && !done; t++) begin
      @(negedge clk);
      if (want_rsp ? (rsp_valid != 0) : (gnt != 0)) begin
        v = want_rsp ? rsp_valid : gnt;
        c = cyc;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_wait: got none after %0d cycles, want one", want_rsp ? "rsp" : "gnt", limit);
    end
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] data;
    logic        err;
    int          dt;
  } vec_t;

  vec_t         tbl[6];
  logic [N-1:0] g;
  logic [N-1:0] v;
  int           gc;
  int           rc;
  logic [15:0]  exp_d[4];
  int           exp_o[6];
  logic [N-1:0] prevg;

  initial begin
    // {requester, a, b, ack latency (0 = never, STUCK = always high), product, err, gnt->rsp cycles}
    tbl[0] = '{0,   8'd5,   8'd6, 3,     16'd30,    1'b0, 3};
    tbl[1] = '{1,   8'd3,   8'd3, 0,     16'd0,     1'b1, EN + TO + 1};
    tbl[2] = '{2,  8'd20,   8'd7, 1,     16'd140,   1'b0, 1};
    tbl[3] = '{3, 8'd255, 8'd255, 2,     16'd65025, 1'b0, 2};
    tbl[4] = '{1,   8'd0,   8'd9, 5,     16'd0,     1'b0, 5};
    tbl[5] = '{2,  8'd13,  8'd11, STUCK, 16'd0,     1'b1, EN + TO + 1};

    repeat (3) tick();
    check("reset_state", 64'({gnt, rsp_valid, rsp_err, m_en, busy, rsp_data, m_a, m_b}), 64'(0));
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      ack_lat = tbl[i].lat;
      repeat (2) tick();
      req_a[tbl[i].idx*8 +: 8] = tbl[i].a;
      req_b[tbl[i].idx*8 +: 8] = tbl[i].b;
      req[tbl[i].idx] = 1'b1;
      wait_evt(1'b0, 10, g, gc);
      check("tbl_gnt", 64'(g), 64'(onehot(tbl[i].idx)));
      check("tbl_operands", 64'({m_a, m_b}), 64'({tbl[i].a, tbl[i].b}));
      tick();
      req = '0;
      wait_evt(1'b1, 150, v, rc);
      check("tbl_rsp", 64'({v, rsp_err, rsp_data}), 64'({onehot(tbl[i].idx), tbl[i].err, tbl[i].data}));
      check("tbl_latency", 64'(rc - gc), 64'(tbl[i].dt));
    end

    // All four requesters at once after reset: strict rotation from 0.
    ack_lat = 3;
    do_reset();
    req_a = {8'd0, 8'd255, 8'd10, 8'd20};
    req_b = {8'd9, 8'd255, 8'd4, 8'd7};
    exp_d = '{16'd140, 16'd40, 16'd65025, 16'd0};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_evt(1'b0, 200, g, gc);
      check("all4_gnt", 64'(g), 64'(onehot(k)));
      tick();
      req = req & ~g;
      wait_evt(1'b1, 200, v, rc);
      check("all4_rsp", 64'({v, rsp_err, rsp_data}), 64'({onehot(k), 1'b0, exp_d[k]}));
    end

    // Two requesters held continuously alternate.
    exp_o = '{0, 2, 0, 2, 0, 2};
    req_a = {8'd0, 8'd6, 8'd0, 8'd4};
    req_b = {8'd0, 8'd7, 8'd0, 8'd5};
    tick();
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_evt(1'b0, 200, g, gc);
      check("hold_gnt", 64'(g), 64'(onehot(exp_o[k])));
      tick();
      if (k == 5) req = '0;
      wait_evt(1'b1, 200, v, rc);
      check("hold_rsp", 64'({v, rsp_data}), 64'({onehot(exp_o[k]), (exp_o[k] == 0) ? 16'd20 : 16'd42}));
    end

    // Reset in the middle of a WAIT abandons the operation and clears the pointer.
    ack_lat = 0;
    tick();
    req_a[15:8] = 8'd3;
    req_b[15:8] = 8'd3;
    req = 4'b0010;
    wait_evt(1'b0, 10, g, gc);
    tick();
    req = '0;
    repeat (5) tick();
    check("pre_reset_wait", 64'({busy, m_en}), 64'(2'b10));
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", 64'({gnt, rsp_valid, rsp_err, m_en, busy, rsp_data, m_a, m_b}), 64'(0));
    ack_lat = 3;
    req_a[31:24] = 8'd2;
    req_b[31:24] = 8'd2;
    req = 4'b1010;
    repeat (2) tick();
    reset_n = 1'b1;
    wait_evt(1'b0, 10, g, gc);
    check("gnt_after_reset", 64'(g), 64'(4'b0010));
    tick();
    req = '0;
    wait_evt(1'b1, 100, v, rc);
    check("rsp_after_reset", 64'({v, rsp_err, rsp_data}), 64'({4'b0010, 1'b0, 16'd9}));

    // Random traffic against the reference model.
    prevg = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 40 == 0) begin
        if ($urandom_range(0, 15) == 0) ack_lat = STUCK;
        else if ($urandom_range(0, 7) == 0) ack_lat = 0;
        else ack_lat = int'($urandom_range(1, 6));
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && prevg[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
          end
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
      prevg = gnt;
    end
    req = '0;
    ack_lat = 3;
    begin
      int t;
      t = 0;
      while (busy && t < 200) begin
        tick();
        t++;
      end
      check("drain_idle", 64'(busy), 64'(0));
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
